// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data memory responder: access size encoding,
// responder FSM states and the latency counter width.
package data_memory_responder_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } mem_state_t;

   // Wide enough for the largest supported latency (15)
   localparam int CNT_W = 4;

   // Raw size field to enum; the unused encoding 2'b11 behaves as a word
   function automatic mem_size_t decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return MEM_BYTE;
         2'b01:   return MEM_HALF;
         default: return MEM_WORD;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_responder_mem_bank.sv
// Word-organised RAM behind the responder: DEPTH_WORDS x 32 bits,
// per-byte write enables, synchronous read.
module data_memory_responder_mem_bank #(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = "",
   localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [3:0]       wr_be,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane writes and registered read; contents are never reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding load/store responder with a fixed
// access latency, byte-lane steering and sign/zero extension of loads.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses fault (no write, rdata 0, err 1); otherwise they are
// aligned down silently and resp_err_out stays 0.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic        req_valid_in,
   output logic        req_ready_out,
   input  logic        req_we_in,
   input  logic [1:0]  req_size_in,
   input  logic        req_unsigned_in,
   input  logic [31:0] req_addr_in,
   input  logic [31:0] req_wdata_in,
   output logic        resp_valid_out,
   input  logic        resp_ready_in,
   output logic [31:0] resp_rdata_out,
   output logic        resp_err_out
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int AW    = IDX_W + 2;

   mem_state_t       state;
   logic [CNT_W-1:0] count;

   logic             we_q;
   mem_size_t        size_q;
   logic             unsigned_q;
   logic [AW-1:0]    addr_q;
   logic [31:0]      wdata_q;

   logic             accept;
   logic             commit;
   logic             fault;
   logic [1:0]       lane_off;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data;
   logic [31:0]      rd_data;
   logic [31:0]      load_value;
   logic [IDX_W-1:0] rd_idx;

   // Byte enables for the access, given the (already aligned) lane offset
   function automatic logic [3:0] lane_enable(input mem_size_t size, input logic [1:0] off);
      case (size)
         MEM_BYTE: return 4'b0001 << off;
         MEM_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:  return 4'b1111;
      endcase
   endfunction

   // Right-justified store data copied onto every lane it could target
   function automatic logic [31:0] replicate(input mem_size_t size, input logic [31:0] data);
      case (size)
         MEM_BYTE: return {4{data[7:0]}};
         MEM_HALF: return {2{data[15:0]}};
         default:  return data;
      endcase
   endfunction

   // Extend a right-justified load; words pass through untouched
   function automatic logic [31:0] extend_load(input logic [31:0] lanes, input mem_size_t size,
                                               input logic zext);
      case (size)
         MEM_BYTE: return {{24{~zext & lanes[7]}}, lanes[7:0]};
         MEM_HALF: return {{16{~zext & lanes[15]}}, lanes[15:0]};
         default:  return lanes;
      endcase
   endfunction

   assign accept = (state == IDLE) && req_valid_in && req_ready_out;
   assign commit = (state == WAIT) && (count == '0);

`ifdef MEM_MISALIGN_TRAP_EN
   assign fault = ((size_q == MEM_HALF) && addr_q[0]) ||
                  ((size_q == MEM_WORD) && (addr_q[1:0] != 2'b00));
`else
   assign fault = 1'b0;
`endif

   // Lane offset with misaligned low bits cleared for half and word accesses
   always_comb begin
      case (size_q)
         MEM_BYTE: lane_off = addr_q[1:0];
         MEM_HALF: lane_off = {addr_q[1], 1'b0};
         default:  lane_off = 2'b00;
      endcase
   end

   // While idle, read the incoming address so data is ready even at LATENCY=1
   assign rd_idx     = (state == IDLE) ? req_addr_in[AW-1:2] : addr_q[AW-1:2];
   assign wr_be      = (commit && we_q && !fault) ? lane_enable(size_q, lane_off) : 4'b0000;
   assign wr_data    = replicate(size_q, wdata_q);
   assign load_value = extend_load(rd_data >> {lane_off, 3'b000}, size_q, unsigned_q);

   // Address bits above the word index wrap silently
   generate
      if (AW < 32) begin : g_addr_wrap
         logic unused_addr_bits;
         assign unused_addr_bits = ^req_addr_in[31:AW];
      end
   endgenerate

   data_memory_responder_mem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_mem_bank (
      .clk     (clk_100mhz),
      .wr_be   (wr_be),
      .wr_idx  (addr_q[AW-1:2]),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // Request capture; datapath registers carry no reset
   always_ff @(posedge clk_100mhz) begin
      if (accept) begin
         we_q       <= req_we_in;
         size_q     <= decode_size(req_size_in);
         unsigned_q <= req_unsigned_in;
         addr_q     <= req_addr_in[AW-1:0];
         wdata_q    <= req_wdata_in;
      end
   end

   // Responder FSM: accept, count down the latency, present and hold the response
   always_ff @(posedge clk_100mhz or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         count          <= '0;
         req_ready_out  <= 1'b0;
         resp_valid_out <= 1'b0;
         resp_rdata_out <= '0;
         resp_err_out   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready_out <= 1'b1;
               if (accept) begin
                  state         <= WAIT;
                  count         <= CNT_W'(LATENCY - 1);
                  req_ready_out <= 1'b0;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  state          <= RESP;
                  resp_valid_out <= 1'b1;
                  resp_rdata_out <= (we_q || fault) ? 32'h0 : load_value;
                  resp_err_out   <= fault;
               end else begin
                  count <= count - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready_in) begin
                  state          <= IDLE;
                  resp_valid_out <= 1'b0;
                  req_ready_out  <= 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               req_ready_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
